sig_stream_ctrl: RTL and testbench

//   Stream controller for the stall-gated SIG_XY / CONV_GAUSS datapath. Converts upstream/downstream

---
 rtl/sig_stream_ctrl.sv | 155 +++++++++++++++
 tb/tb_sig_stream_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_stream_ctrl.sv
// Stream controller for the stall-gated SIG_XY / CONV_GAUSS datapath: maps valid/ready handshakes
// onto one global stall, tracks frame position and flushes the pipeline at end of frame.
module sig_stream_ctrl #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int PIPE_LATENCY    = 67,
  localparam int BPL = IMAGE_DIM / PIXELS_PER_BEAT,
  localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1,
  localparam int LW  = $clog2(IMAGE_DIM)
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          enable,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          stall,
  output logic [BW-1:0] beat_idx,
  output logic [LW-1:0] line_idx,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_err
);

  localparam int FRAME_BEATS = IMAGE_DIM * BPL;
  localparam int OW          = $clog2(FRAME_BEATS);
  localparam logic [BW-1:0] BEAT_MAX = BW'(BPL - 1);
  localparam logic [LW-1:0] LINE_MAX = LW'(IMAGE_DIM - 1);
  localparam logic [OW-1:0] OUT_MAX  = OW'(FRAME_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [PIPE_LATENCY-1:0] vld_sr_r;
  logic [BW-1:0]           beat_r;
  logic [LW-1:0]           line_r;
  logic [OW-1:0]           out_cnt_r;
  logic                    frame_done_r;
  logic                    frame_err_r;

  logic blocked_s;
  logic advance_s;
  logic s_ready_s;
  logic accept_s;
  logic out_hs_s;
  logic in_last_s;
  logic out_last_s;
  logic frame_end_s;

  assign m_valid     = vld_sr_r[PIPE_LATENCY-1];
  assign blocked_s   = m_valid & ~m_ready;
  assign out_hs_s    = m_valid & m_ready;
  assign in_last_s   = (beat_r == BEAT_MAX) && (line_r == LINE_MAX);
  assign out_last_s  = (out_cnt_r == OUT_MAX);
  assign frame_end_s = (state_r == ST_FLUSH) & out_hs_s & out_last_s;
  assign accept_s    = s_valid & s_ready_s;

  // Next-state, input handshake and pipeline advance decode
  always_comb begin
    state_nxt_s = state_r;
    s_ready_s   = 1'b0;
    advance_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable) state_nxt_s = ST_RUN;
        else        state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        s_ready_s = ~blocked_s;
        advance_s = s_valid & ~blocked_s;
        if (advance_s && in_last_s) state_nxt_s = ST_FLUSH;
        else                        state_nxt_s = ST_RUN;
      end
      ST_FLUSH: begin
        advance_s = ~blocked_s;
        if (out_hs_s && out_last_s) state_nxt_s = ST_IDLE;
        else                        state_nxt_s = ST_FLUSH;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign s_ready    = s_ready_s;
  assign stall      = ~advance_s;
  assign m_last     = m_valid & out_last_s;
  assign busy       = (state_r != ST_IDLE);
  assign beat_idx   = beat_r;
  assign line_idx   = line_r;
  assign frame_done = frame_done_r;
  assign frame_err  = frame_err_r;

  // State register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Per-slot valid bits; a consumed output slot is cleared so it is never re-presented
  always_ff @(posedge clk or posedge areset) begin
    if (areset)                  vld_sr_r <= '0;
    else if (advance_s)          vld_sr_r <= {vld_sr_r[PIPE_LATENCY-2:0], (state_r == ST_RUN)};
    else if (out_hs_s)           vld_sr_r[PIPE_LATENCY-1] <= 1'b0;
    else                         vld_sr_r <= vld_sr_r;
  end

  // Column/row position of the next input beat
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      beat_r <= '0;
      line_r <= '0;
    end else if (frame_end_s) begin
      beat_r <= '0;
      line_r <= '0;
    end else if (accept_s) begin
      if (beat_r == BEAT_MAX) begin
        beat_r <= '0;
        line_r <= (line_r == LINE_MAX) ? '0 : line_r + 1'b1;
      end else begin
        beat_r <= beat_r + 1'b1;
        line_r <= line_r;
      end
    end else begin
      beat_r <= beat_r;
      line_r <= line_r;
    end
  end

  // Output beat counter
  always_ff @(posedge clk or posedge areset) begin
    if (areset)           out_cnt_r <= '0;
    else if (frame_end_s) out_cnt_r <= '0;
    else if (out_hs_s)    out_cnt_r <= out_cnt_r + 1'b1;
    else                  out_cnt_r <= out_cnt_r;
  end

  // Status pulses, registered one cycle after the event
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      frame_done_r <= frame_end_s;
      frame_err_r  <= accept_s & (s_last ^ in_last_s);
    end
  end

endmodule

// File: tb/tb_sig_stream_ctrl.sv
// Self-checking bench for sig_stream_ctrl: scoreboard of accepted beats against output handshakes,
// with a stall-gated tag pipeline standing in for the datapath.
module tb_sig_stream_ctrl;

  localparam int PPB = 16;
  localparam int DIM = 64;
  localparam int LAT = 11;
  localparam int BPL = DIM / PPB;
  localparam int FB  = DIM * BPL;

  logic       clk;
  logic       areset;
  logic       enable;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       stall;
  logic [1:0] beat_idx;
  logic [5:0] line_idx;
  logic       busy;
  logic       frame_done;
  logic       frame_err;

  sig_stream_ctrl #(
    .PIXELS_PER_BEAT(PPB),
    .IMAGE_DIM      (DIM),
    .PIPE_LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .areset    (areset),
    .enable    (enable),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .stall     (stall),
    .beat_idx  (beat_idx),
    .line_idx  (line_idx),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  typedef struct {
    int tag;
    int idx;
  } sb_t;

  sb_t sb_q[$];
  int  pipe [LAT];
  int  n_checks = 0;
  int  n_errs   = 0;
  int  cyc      = 0;
  int  acc_tag  = 0;
  int  in_idx   = 0;
  int  frame_acc = 0;
  int  frame_hs  = 0;
  int  err_cnt   = 0;
  int  done_cnt  = 0;
  int  first_acc_cyc = -1;
  int  first_mv_cyc  = -1;
  int  mr_mode = 0;
  logic acc_flag = 1'b0;
  logic exp_done = 1'b0;
  logic exp_err  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: sample at the falling edge what the next rising edge will commit
  always @(negedge clk) begin
    sb_t e;
    logic acc;
    if (areset) begin
      sb_q.delete();
      for (int i = 0; i < LAT; i++) pipe[i] = -1;
      in_idx   = 0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      acc_flag = 1'b0;
    end else begin
      cyc++;
      check_eq("frame_done", frame_done, exp_done);
      check_eq("frame_err", frame_err, exp_err);
      if (frame_done) done_cnt++;
      if (frame_err) err_cnt++;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      acc      = s_valid & s_ready;
      acc_flag = acc;
      if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
      if (m_valid && !m_ready) begin
        check_eq("blk_s_ready", s_ready, 0);
        check_eq("blk_stall", stall, 1);
      end
      if (m_valid && sb_q.size() > 0) check_eq("m_last", m_last, (sb_q[0].idx == FB - 1));
      else check_eq("m_last_idle", m_last, 0);
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check_eq("out_tag", pipe[LAT-1], e.tag);
          exp_done = (e.idx == FB - 1);
          frame_hs++;
        end
      end
      if (acc) begin
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        check_eq("acc_stall", stall, 0);
        check_eq("beat_idx", beat_idx, in_idx % BPL);
        check_eq("line_idx", line_idx, in_idx / BPL);
        sb_q.push_back('{tag: acc_tag, idx: in_idx});
        exp_err = (s_last != (in_idx == FB - 1));
        in_idx  = (in_idx + 1) % FB;
        frame_acc++;
      end
      if (!stall) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = acc ? acc_tag : -1;
      end
      if (acc) acc_tag++;
    end
  end

  // Downstream ready pattern
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(1));
      endcase
    end
  end

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_s_ready"}, s_ready, 0);
    check_eq({pfx, "_m_valid"}, m_valid, 0);
    check_eq({pfx, "_m_last"}, m_last, 0);
    check_eq({pfx, "_stall"}, stall, 1);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_frame_done"}, frame_done, 0);
    check_eq({pfx, "_frame_err"}, frame_err, 0);
    check_eq({pfx, "_beat_idx"}, beat_idx, 0);
    check_eq({pfx, "_line_idx"}, line_idx, 0);
  endtask

  task automatic start_frame();
    frame_acc = 0;
    frame_hs  = 0;
  endtask

  task automatic send_frame(input int pct, input int last_pos, input int stop_after, input int en_off_at);
    int k = 0;
    int guard = 0;
    while (k < FB && k < stop_after && guard < 5000) begin
      if (k == en_off_at) enable = 1'b0;
      s_valid = ($urandom_range(99) < pct);
      s_last  = (k == last_pos);
      @(posedge clk);
      #1;
      if (acc_flag) k++;
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check_eq("send_beats", k, (stop_after < FB) ? stop_after : FB);
  endtask

  task automatic wait_done();
    int n = 0;
    int start = done_cnt;
    while (done_cnt == start && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("done_seen", done_cnt - start, 1);
    check_eq("frame_acc", frame_acc, FB);
    check_eq("frame_hs", frame_hs, FB);
    check_eq("sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    int err_base;
    areset  = 1'b1;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    areset  = 1'b0;
    s_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_busy", busy, 0);
    check_eq("idle_s_ready", s_ready, 0);
    check_eq("idle_stall", stall, 1);
    s_valid = 1'b0;

    // Full-rate frame, checks pipeline latency
    enable = 1'b1;
    start_frame();
    err_base = err_cnt;
    send_frame(100, FB - 1, FB, -1);
    wait_done();
    check_eq("latency", first_mv_cyc - first_acc_cyc, LAT);
    check_eq("t1_no_err", err_cnt - err_base, 0);

    // Toggling downstream ready
    mr_mode = 1;
    start_frame();
    send_frame(100, FB - 1, FB, -1);
    wait_done();
    mr_mode = 0;

    // Sparse upstream valid
    start_frame();
    send_frame(50, FB - 1, FB, -1);
    wait_done();

    // Early s_last, missing final s_last, enable dropped mid-frame
    start_frame();
    err_base = err_cnt;
    send_frame(100, 100, FB, 150);
    wait_done();
    check_eq("t4_err_pulses", err_cnt - err_base, 2);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t4_stay_idle", busy, 0);
    enable = 1'b1;

    // Mid-frame reset, then a clean frame
    start_frame();
    send_frame(100, FB - 1, 40, -1);
    areset = 1'b1;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
    start_frame();
    send_frame(100, FB - 1, FB, -1);
    wait_done();

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
